// File: rtl/mac_sequencer.sv
// Dot-product job controller: streams operand pairs into the pipelined
// multiplier, tracks its latency with a tag pipe and accumulates the products.
module mac_sequencer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned MUL_WIDTH   = 32,
  parameter int unsigned ACC_WIDTH   = 40,
  parameter int unsigned LEN_WIDTH   = 8,
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] mul_a,
  output logic [DATA_WIDTH-1:0] mul_b,
  input  logic [MUL_WIDTH-1:0]  mul_p,
  output logic                  busy,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  output logic                  overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    len_q, issued_q, issued_inc;
  logic [MUL_LATENCY:0]    tag_q;
  logic [ACC_WIDTH-1:0]    acc_q, result_q;
  logic                    ovf_q;
  logic [DATA_WIDTH-1:0]   mul_a_q, mul_b_q;
  logic [ACC_WIDTH:0]      sum;
  logic                    xfer, last_xfer, tag_out, final_acc, accept;

  assign accept     = (state_q == IDLE) && start;
  assign xfer       = (state_q == RUN) && in_valid;
  assign issued_inc = issued_q + LEN_WIDTH'(1);
  assign last_xfer  = xfer && (issued_inc == len_q);
  // Tag pipe is one stage longer than the multiplier: the operand register
  // itself adds one edge before the multiplier sees the pair.
  assign tag_out    = tag_q[MUL_LATENCY];
  assign final_acc  = (state_q == DRAIN) && tag_out && (tag_q[MUL_LATENCY-1:0] == '0);
  assign sum        = {1'b0, acc_q} + (ACC_WIDTH+1)'(mul_p);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : RUN;
      RUN:     if (last_xfer) state_d = DRAIN;
      DRAIN:   if (final_acc) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    case (state_q)
      IDLE:    busy = 1'b0;
      RUN:     in_ready = 1'b1;
      DONE:    result_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      issued_q <= '0;
      tag_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
    end else begin
      tag_q <= {tag_q[MUL_LATENCY-1:0], xfer};
      if (xfer) begin
        mul_a_q  <= a_in;
        mul_b_q  <= b_in;
        issued_q <= issued_inc;
      end
      if (accept) begin
        len_q    <= len;
        issued_q <= '0;
        acc_q    <= '0;
        ovf_q    <= 1'b0;
        if (len == '0) result_q <= '0;
      end else if (tag_out) begin
        acc_q <= sum[ACC_WIDTH-1:0];
        if (sum[ACC_WIDTH]) ovf_q <= 1'b1;
        if (final_acc) result_q <= sum[ACC_WIDTH-1:0];
      end
    end
  end

  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign result   = result_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: three instances (latency 1, latency 3,
// 32-bit accumulator) share one stimulus stream, each with its own multiplier model.
module tb_mac_sequencer;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0]  len = '0;
  logic [15:0] a_in = '0, b_in = '0;

  logic        rdy1, busy1, rv1, ovf1;
  logic [15:0] ma1, mb1;
  logic [31:0] p1 = '0;
  logic [39:0] res1;

  logic        rdy3, busy3, rv3, ovf3;
  logic [15:0] ma3, mb3;
  logic [31:0] p3 = '0, p3a = '0, p3b = '0;
  logic [39:0] res3;

  logic        rdy32, busy32, rv32, ovf32;
  logic [15:0] ma32, mb32;
  logic [31:0] p32 = '0;
  logic [31:0] res32;

  int n_chk = 0, n_fail = 0;
  int edge_n = 0, rv1_cnt = 0, rv3_cnt = 0, rv1_edge = 0, rv3_edge = 0;

  mac_sequencer u1 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .in_ready(rdy1), .mul_a(ma1), .mul_b(mb1),
    .mul_p(p1), .busy(busy1), .result(res1), .result_valid(rv1), .overflow(ovf1));

  mac_sequencer #(.MUL_LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .in_ready(rdy3), .mul_a(ma3), .mul_b(mb3),
    .mul_p(p3), .busy(busy3), .result(res3), .result_valid(rv3), .overflow(ovf3));

  mac_sequencer #(.ACC_WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .in_ready(rdy32), .mul_a(ma32), .mul_b(mb32),
    .mul_p(p32), .busy(busy32), .result(res32), .result_valid(rv32), .overflow(ovf32));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p1  <= 32'(ma1) * 32'(mb1);
    p3a <= 32'(ma3) * 32'(mb3);
    p3b <= p3a;
    p3  <= p3b;
    p32 <= 32'(ma32) * 32'(mb32);
  end

  always @(posedge clk) edge_n++;

  always @(negedge clk) begin
    if (rv1) begin rv1_cnt++; rv1_edge = edge_n; end
    if (rv3) begin rv3_cnt++; rv3_edge = edge_n; end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] l);
    start = 1'b1; len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1; a_in = a; b_in = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((busy1 || busy3 || busy32) && n < lim) begin tick(); n++; end
    n_chk++;
    if (n >= lim) begin n_fail++; $display("FAIL idle_timeout: got busy after %0d cycles, required idle", n); end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    n_chk++; if ({rdy1, busy1, rv1, ovf1} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b required 0000", {rdy1, busy1, rv1, ovf1}); end
    n_chk++; if ({ma1, mb1} !== 32'h0) begin n_fail++; $display("FAIL reset_mul: got %h required 0", {ma1, mb1}); end
    n_chk++; if (res1 !== 40'h0) begin n_fail++; $display("FAIL reset_result: got %h required 0", res1); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int b1 = rv1_cnt, b3 = rv3_cnt, kl;
    pulse_start(8'd4);
    n_chk++; if ({rdy1, busy1, rdy3} !== 3'b111) begin n_fail++; $display("FAIL basic_ready: got %b required 111", {rdy1, busy1, rdy3}); end
    push(16'd1, 16'd2); push(16'd3, 16'd4); push(16'd5, 16'd6); push(16'd7, 16'd8);
    kl = edge_n;
    n_chk++; if (rdy1 !== 1'b0) begin n_fail++; $display("FAIL basic_drain_ready: got %b required 0", rdy1); end
    wait_idle(20);
    n_chk++; if (res1 !== 40'd100) begin n_fail++; $display("FAIL basic_result1: got %0d required 100", res1); end
    n_chk++; if (res3 !== 40'd100) begin n_fail++; $display("FAIL basic_result3: got %0d required 100", res3); end
    n_chk++; if (rv1_cnt - b1 !== 1) begin n_fail++; $display("FAIL basic_pulses1: got %0d required 1", rv1_cnt - b1); end
    n_chk++; if (rv3_cnt - b3 !== 1) begin n_fail++; $display("FAIL basic_pulses3: got %0d required 1", rv3_cnt - b3); end
    n_chk++; if (rv1_edge !== kl + 2) begin n_fail++; $display("FAIL basic_rv_time1: got edge %0d required %0d", rv1_edge, kl + 2); end
    n_chk++; if (rv3_edge !== kl + 4) begin n_fail++; $display("FAIL basic_rv_time3: got edge %0d required %0d", rv3_edge, kl + 4); end
    n_chk++; if (ovf1 !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %b required 0", ovf1); end
  endtask

  task automatic test_stalls();
    int b1 = rv1_cnt, kl = 0;
    logic [15:0] av[4] = '{16'd1, 16'd3, 16'd5, 16'd7};
    logic [15:0] bv[4] = '{16'd2, 16'd4, 16'd6, 16'd8};
    pulse_start(8'd4);
    for (int i = 0; i < 4; i++) begin
      push(av[i], bv[i]);
      kl = edge_n;
      if (i < 3) begin
        n_chk++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b required 1", i, rdy1); end
        tick();
      end
    end
    wait_idle(20);
    n_chk++; if (res1 !== 40'd100) begin n_fail++; $display("FAIL stall_result: got %0d required 100", res1); end
    n_chk++; if (rv1_cnt - b1 !== 1) begin n_fail++; $display("FAIL stall_pulses: got %0d required 1", rv1_cnt - b1); end
    n_chk++; if (rv1_edge !== kl + 2) begin n_fail++; $display("FAIL stall_rv_time: got edge %0d required %0d", rv1_edge, kl + 2); end
  endtask

  task automatic test_overflow();
    pulse_start(8'd2);
    push(16'hFFFF, 16'hFFFF); push(16'hFFFF, 16'hFFFF);
    wait_idle(20);
    n_chk++; if (res32 !== 32'hFFFC0002) begin n_fail++; $display("FAIL ovf_result32: got %h required fffc0002", res32); end
    n_chk++; if (ovf32 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag32: got %b required 1", ovf32); end
    n_chk++; if (res1 !== 40'h01FFFC0002) begin n_fail++; $display("FAIL ovf_result40: got %h required 01fffc0002", res1); end
    n_chk++; if (ovf1 !== 1'b0) begin n_fail++; $display("FAIL ovf_flag40: got %b required 0", ovf1); end
    pulse_start(8'd1);
    push(16'd1, 16'd1);
    wait_idle(20);
    n_chk++; if (res32 !== 32'd1) begin n_fail++; $display("FAIL ovf_next_result: got %h required 1", res32); end
    n_chk++; if (ovf32 !== 1'b0) begin n_fail++; $display("FAIL ovf_next_flag: got %b required 0", ovf32); end
  endtask

  task automatic test_zero_len();
    pulse_start(8'd0);
    n_chk++; if ({rv1, busy1} !== 2'b11) begin n_fail++; $display("FAIL zero_pulse: got %b required 11", {rv1, busy1}); end
    n_chk++; if (res1 !== 40'h0) begin n_fail++; $display("FAIL zero_result: got %h required 0", res1); end
    tick();
    n_chk++; if ({rv1, busy1} !== 2'b00) begin n_fail++; $display("FAIL zero_after: got %b required 00", {rv1, busy1}); end
  endtask

  task automatic test_ignored_start();
    int b1 = rv1_cnt;
    pulse_start(8'd3);
    push(16'd2, 16'd3);
    start = 1'b1; len = 8'd7;
    push(16'd3, 16'd4);
    start = 1'b0;
    push(16'd4, 16'd5);
    wait_idle(20);
    tick(); tick();
    n_chk++; if (res1 !== 40'd38) begin n_fail++; $display("FAIL ign_result: got %0d required 38", res1); end
    n_chk++; if (rv1_cnt - b1 !== 1) begin n_fail++; $display("FAIL ign_pulses: got %0d required 1", rv1_cnt - b1); end
    n_chk++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL ign_busy: got %b required 0", busy1); end
  endtask

  task automatic test_reset_mid();
    int b1, b3;
    pulse_start(8'd5);
    push(16'd1, 16'd1); push(16'd2, 16'd2);
    #1 rst = 1'b1;
    #1;
    n_chk++; if ({rdy1, busy1, rv1, ovf1, busy3} !== 5'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got %b required 00000", {rdy1, busy1, rv1, ovf1, busy3}); end
    n_chk++; if ({ma1, mb1} !== 32'h0) begin n_fail++; $display("FAIL rstmid_mul: got %h required 0", {ma1, mb1}); end
    n_chk++; if (res1 !== 40'h0) begin n_fail++; $display("FAIL rstmid_result: got %h required 0", res1); end
    b1 = rv1_cnt; b3 = rv3_cnt;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    n_chk++; if ((rv1_cnt - b1) + (rv3_cnt - b3) !== 0) begin n_fail++; $display("FAIL rstmid_no_pulse: got %0d required 0", (rv1_cnt - b1) + (rv3_cnt - b3)); end
    pulse_start(8'd1);
    push(16'd9, 16'd9);
    wait_idle(20);
    n_chk++; if (res1 !== 40'd81) begin n_fail++; $display("FAIL rstmid_next1: got %0d required 81", res1); end
    n_chk++; if (res3 !== 40'd81) begin n_fail++; $display("FAIL rstmid_next3: got %0d required 81", res3); end
  endtask

  task automatic test_back_to_back();
    int b1 = rv1_cnt, b3 = rv3_cnt, n = 0;
    pulse_start(8'd1);
    push(16'd2, 16'd2);
    while (!rv1 && n < 10) begin tick(); n++; end
    n_chk++; if (n >= 10) begin n_fail++; $display("FAIL b2b_wait: got no result_valid in %0d cycles, required pulse", n); end
    tick();
    n_chk++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy %b required 0", busy1); end
    pulse_start(8'd1);
    n_chk++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b required 1", rdy1); end
    push(16'd3, 16'd3);
    wait_idle(20);
    n_chk++; if (res1 !== 40'd9) begin n_fail++; $display("FAIL b2b_result1: got %0d required 9", res1); end
    n_chk++; if (rv1_cnt - b1 !== 2) begin n_fail++; $display("FAIL b2b_pulses1: got %0d required 2", rv1_cnt - b1); end
    n_chk++; if (res3 !== 40'd4) begin n_fail++; $display("FAIL b2b_result3: got %0d required 4", res3); end
    n_chk++; if (rv3_cnt - b3 !== 1) begin n_fail++; $display("FAIL b2b_pulses3: got %0d required 1", rv3_cnt - b3); end
  endtask

  task automatic test_latency_sweep();
    int b1 = rv1_cnt, b3 = rv3_cnt, kl;
    pulse_start(8'd255);
    for (int i = 0; i < 255; i++) push(16'hFFFF, 16'hFFFF);
    kl = edge_n;
    wait_idle(20);
    n_chk++; if (res1 !== 40'hFEFE0200FF) begin n_fail++; $display("FAIL sweep_result1: got %h required fefe0200ff", res1); end
    n_chk++; if (res3 !== 40'hFEFE0200FF) begin n_fail++; $display("FAIL sweep_result3: got %h required fefe0200ff", res3); end
    n_chk++; if ({ovf1, ovf3} !== 2'b00) begin n_fail++; $display("FAIL sweep_overflow: got %b required 00", {ovf1, ovf3}); end
    n_chk++; if (rv1_edge !== kl + 2) begin n_fail++; $display("FAIL sweep_rv_time1: got edge %0d required %0d", rv1_edge, kl + 2); end
    n_chk++; if (rv3_edge !== kl + 4) begin n_fail++; $display("FAIL sweep_rv_time3: got edge %0d required %0d", rv3_edge, kl + 4); end
    n_chk++; if ((rv1_cnt - b1) * 10 + (rv3_cnt - b3) !== 11) begin n_fail++; $display("FAIL sweep_pulses: got %0d required 11", (rv1_cnt - b1) * 10 + (rv3_cnt - b3)); end
    n_chk++; if ({res32, ovf32} !== {32'hFE0200FF, 1'b1}) begin n_fail++; $display("FAIL sweep_acc32: got %h/%b required fe0200ff/1", res32, ovf32); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_overflow();
    test_zero_len();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_latency_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by %0t, required completion", $time);
    $fatal(1);
  end

endmodule
